// File: rtl/arith_op_sequencer.sv
// rtl/arith_op_sequencer.sv - steps the arithmetic unit opcode through a latched program (optional macro: SEQ_RETRIG_EN)
module arith_op_sequencer #(
    parameter int         NUM_SLOTS   = 4,
    parameter int         DWELL_W     = 16,
    parameter int         AU_LATENCY  = 1,
    parameter logic [1:0] IDLE_OPCODE = 2'b00
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               Trigger,
    input  logic               Abort,
    input  logic [7:0]         Program,
    input  logic [1:0]         NumSteps,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Loop,
    output logic [1:0]         OpCode,
    output logic [1:0]         StepIdx,
    output logic               Busy,
    output logic               ResultValid,
    output logic               Done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Cycle index within a step at which the unit result first matches the opcode.
    localparam logic [DWELL_W-1:0] LAT = DWELL_W'(AU_LATENCY);

    state_t             state, state_n;
    logic               trig_q;
    logic               rise;
    logic               start;
    logic [7:0]         prog_q, prog_n;
    logic [1:0]         nsteps_q, nsteps_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic               loop_q, loop_n;
    logic [1:0]         step_n;
    logic [DWELL_W-1:0] cyc_q, cyc_n;
    logic               busy_n;
    logic               done_n;
    logic [1:0]         opcode_n;
    logic               rv_n;

    assign rise = Trigger & ~trig_q;

    // Next-state and registered-output values; the opcode is picked from the
    // configuration that will be latched, so a start shows slot 0 immediately.
    always_comb begin
        state_n  = state;
        prog_n   = prog_q;
        nsteps_n = nsteps_q;
        dwell_n  = dwell_q;
        loop_n   = loop_q;
        step_n   = StepIdx;
        cyc_n    = cyc_q;
        done_n   = 1'b0;
        start    = 1'b0;
        case (state)
            ST_IDLE: begin
                step_n = 2'd0;
                cyc_n  = '0;
                if (rise && Enable && !Abort) begin
                    start = 1'b1;
                end
            end
            ST_RUN: begin
                if (Abort || !Enable) begin
                    state_n = ST_IDLE;
                    step_n  = 2'd0;
                    cyc_n   = '0;
                end
`ifdef SEQ_RETRIG_EN
                else if (rise) begin
                    start = 1'b1;
                end
`endif
                else if (cyc_q == dwell_q - DWELL_W'(1)) begin
                    cyc_n  = '0;
                    step_n = 2'd0;
                    if (StepIdx != nsteps_q) begin
                        step_n = StepIdx + 2'd1;
                    end else if (!loop_q) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cyc_n = cyc_q + DWELL_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                step_n  = 2'd0;
                cyc_n   = '0;
            end
        endcase
        if (start) begin
            state_n  = ST_RUN;
            prog_n   = Program;
            nsteps_n = NumSteps;
            dwell_n  = (Dwell == '0) ? DWELL_W'(1) : Dwell;
            loop_n   = Loop;
            step_n   = 2'd0;
            cyc_n    = '0;
        end
        busy_n   = (state_n == ST_RUN);
        opcode_n = busy_n ? prog_n[{step_n, 1'b0} +: 2] : IDLE_OPCODE;
        rv_n     = busy_n && (cyc_n >= LAT);
    end

    // State, configuration latches, counters and all outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            trig_q      <= 1'b0;
            prog_q      <= '0;
            nsteps_q    <= '0;
            dwell_q     <= DWELL_W'(1);
            loop_q      <= 1'b0;
            cyc_q       <= '0;
            StepIdx     <= 2'd0;
            OpCode      <= IDLE_OPCODE;
            Busy        <= 1'b0;
            ResultValid <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state       <= state_n;
            trig_q      <= Trigger;
            prog_q      <= prog_n;
            nsteps_q    <= nsteps_n;
            dwell_q     <= dwell_n;
            loop_q      <= loop_n;
            cyc_q       <= cyc_n;
            StepIdx     <= step_n;
            OpCode      <= opcode_n;
            Busy        <= busy_n;
            ResultValid <= rv_n;
            Done        <= done_n;
        end
    end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// tb/tb_arith_op_sequencer.sv - directed self-checking bench for arith_op_sequencer
module tb_arith_op_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b0;
    logic        Trigger = 1'b0;
    logic        Abort = 1'b0;
    logic [7:0]  Program = 8'h00;
    logic [1:0]  NumSteps = 2'd0;
    logic [15:0] Dwell = 16'd0;
    logic        Loop = 1'b0;
    logic [1:0]  OpCode;
    logic [1:0]  StepIdx;
    logic        Busy;
    logic        ResultValid;
    logic        Done;

    int checks = 0;
    int failures = 0;

    arith_op_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .Trigger     (Trigger),
        .Abort       (Abort),
        .Program     (Program),
        .NumSteps    (NumSteps),
        .Dwell       (Dwell),
        .Loop        (Loop),
        .OpCode      (OpCode),
        .StepIdx     (StepIdx),
        .Busy        (Busy),
        .ResultValid (ResultValid),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_op"}, OpCode, 0);
        check({tag, "_idx"}, StepIdx, 0);
        check({tag, "_rv"}, ResultValid, 0);
        check({tag, "_done"}, Done, 0);
    endtask

    int done_cnt;
    int busy_cnt;

    initial begin
        // Reset values
        #2;
        check_idle("rst");
        tick();
        Reset = 1'b1;
        Enable = 1'b1;
        tick();

        // Test 1: asynchronous reset mid-run
        Program = 8'b11_10_01_00; NumSteps = 2'd3; Dwell = 16'd10; Loop = 1'b0;
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        check("t1_busy", Busy, 1);
        tick(); tick();
        Reset = 1'b0;
        #1;
        check_idle("t1_async");
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_stay_busy", Busy, 0);
            check("t1_stay_done", Done, 0);
        end

        // Test 2: four steps, dwell 3, one-shot
        Program = 8'b11_10_01_00; NumSteps = 2'd3; Dwell = 16'd3; Loop = 1'b0;
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("t2_busy", Busy, 1);
            check("t2_op", OpCode, i / 3);
            check("t2_idx", StepIdx, i / 3);
            check("t2_rv", ResultValid, (i % 3) != 0);
            check("t2_done", Done, 0);
            tick();
        end
        check("t2_done_pulse", Done, 1);
        check("t2_done_busy", Busy, 0);
        check("t2_done_op", OpCode, 0);
        tick();
        check("t2_done_once", Done, 0);

        // Test 3: dwell 0 treated as 1; rise in the Done cycle restarts
        Program = 8'b00_00_10_01; NumSteps = 2'd1; Dwell = 16'd0; Loop = 1'b0;
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        check("t3_op0", OpCode, 1);
        check("t3_rv0", ResultValid, 0);
        tick();
        check("t3_op1", OpCode, 2);
        check("t3_idx1", StepIdx, 1);
        check("t3_rv1", ResultValid, 0);
        tick();
        check("t3_done", Done, 1);
        check("t3_done_busy", Busy, 0);
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        check("t3_restart_busy", Busy, 1);
        check("t3_restart_op", OpCode, 1);
        check("t3_restart_done", Done, 0);
        tick(); tick();
        check("t3_done2", Done, 1);
        tick();

        // Test 4: looping, then Enable low
        Program = 8'b00_00_01_11; NumSteps = 2'd1; Dwell = 16'd2; Loop = 1'b1;
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("t4_op", OpCode, ((i / 2) % 2) != 0 ? 1 : 3);
            check("t4_idx", StepIdx, (i / 2) % 2);
            check("t4_rv", ResultValid, (i % 2) == 1);
            check("t4_done", Done, 0);
            tick();
        end
        Enable = 1'b0;
        tick();
        check_idle("t4_disable");
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        Enable = 1'b1;
        tick();
        check("t4_rise_discarded", Busy, 0);

        // Test 5: Trigger held high, Program changed mid-run
        Program = 8'b00_00_00_10; NumSteps = 2'd0; Dwell = 16'd2; Loop = 1'b0;
        Trigger = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 1) Program = 8'hFF;
            if (Busy) begin
                busy_cnt++;
                check("t5_op", OpCode, 2);
            end
            if (Done) done_cnt++;
        end
        Trigger = 1'b0;
        check("t5_done_count", done_cnt, 1);
        check("t5_busy_count", busy_cnt, 2);
        tick();

        // Abort has priority over a start request
        Program = 8'b11_10_01_00; NumSteps = 2'd3; Dwell = 16'd4; Loop = 1'b0;
        Trigger = 1'b1; Abort = 1'b1;
        tick();
        Trigger = 1'b0; Abort = 1'b0;
        check("t6_abort_start", Busy, 0);
        tick();

        // Test 6: abort during the second step
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6_pre_idx", StepIdx, 1);
        check("t6_pre_op", OpCode, 1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check_idle("t6_abort");
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done) done_cnt++;
        end
        check("t6_no_done", done_cnt, 0);

        // Rise during RUN: restart with the macro, ignored without it
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6_rt_pre_idx", StepIdx, 1);
        Trigger = 1'b1;
        tick();
        Trigger = 1'b0;
`ifdef SEQ_RETRIG_EN
        check("t6_rt_idx", StepIdx, 0);
        check("t6_rt_op", OpCode, 0);
        check("t6_rt_busy", Busy, 1);
        check("t6_rt_rv", ResultValid, 0);
        tick();
        check("t6_rt_rv2", ResultValid, 1);
        check("t6_rt_done", Done, 0);
`else
        check("t6_rt_idx", StepIdx, 1);
        check("t6_rt_op", OpCode, 1);
        check("t6_rt_busy", Busy, 1);
        check("t6_rt_rv", ResultValid, 1);
`endif
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("t6_rt_end", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_op_sequencer.md
Name: arith_op_sequencer

Overview:
Sequencer that drives the 2-bit OpCode of the shared arithmetic unit through a short programmed list of operations. Each step holds its opcode for a configurable dwell time.
- Started by a trigger edge (ExtTrig or a control bit).
- Runs one-shot or looping.
- Flags the cycles in which the unit's result corresponds to the current opcode, so downstream capture logic knows when OutputA is meaningful.

Parameters:
NUM_SLOTS, 4, number of program slots (opcode list length); fixed at 4 in this revision.
DWELL_W, 16, width of the dwell counter and the Dwell input.
AU_LATENCY, 1, clock cycles from an OpCode change to a matching Result.
IDLE_OPCODE, 2'b00, opcode driven while not running.

Ports:
Clk  in  1  system clock, all logic rising-edge.
Reset  in  1  asynchronous, active-low reset (0 = reset).
Enable  in  1  sequencer enable; low forces IDLE.
Trigger  in  1  start request; rising edge detected internally.
Abort  in  1  synchronous abort of a running sequence.
Program  in  8  four 2-bit opcodes; slot k = Program[2k+1:2k].
NumSteps  in  2  index of last slot to execute (0..3).
Dwell  in  DWELL_W  cycles per step; 0 treated as 1.
Loop  in  1  1 = restart at slot 0 after last slot.
OpCode  out  2  opcode to the arithmetic unit.
StepIdx  out  2  current slot index.
Busy  out  1  high while in RUN.
ResultValid  out  1  unit result matches current opcode.
Done  out  1  one-cycle pulse at normal sequence completion.

Behaviour:
- Reset (async, Reset=0): OpCode=IDLE_OPCODE, StepIdx=0, Busy=0, ResultValid=0, Done=0, state=IDLE, trigger history=0.
- Edge detect: trig_q registers Trigger; rise = Trigger & ~trig_q. Trigger held high gives exactly one start.
- All outputs registered.

States:
- IDLE: OpCode=IDLE_OPCODE, Busy=0.
  - rise & Enable & ~Abort in cycle t: latch Program, NumSteps, Dwell (0→1) and Loop; load dwell counter; enter RUN.
  - At t+1: Busy=1, StepIdx=0, OpCode=slot0.
  - rise while Enable=0 is discarded, not remembered.
- RUN:
  - Each step lasts exactly D = max(Dwell,1) cycles.
  - ResultValid=1 from the (AU_LATENCY+1)th cycle of the step through the step's last cycle. If D <= AU_LATENCY, ResultValid stays 0 for that step.
  - At end of a step with StepIdx < latched NumSteps: StepIdx+1 and the new opcode appear in the next cycle.
  - At end of the last step:
    - latched Loop=1: StepIdx=0, continue.
    - latched Loop=0: next cycle Busy=0, OpCode=IDLE_OPCODE, StepIdx=0, Done=1 for one cycle, state=IDLE.
  - Abort=1 or Enable=0 in any RUN cycle: next cycle goes to IDLE outputs, Done=0, ResultValid=0. Abort has priority over step advance and trigger.
  - Input changes to Program/NumSteps/Dwell/Loop during RUN have no effect; they are latched only at start.
  - Trigger rise during RUN: ignored (see optional feature).
- Done and a new start: a rise in the Done cycle starts a new run; Busy=1 on the following cycle.
- Reset mid-run: immediate return to reset values, no Done.

Optional Feature:
Macro SEQ_RETRIG_EN.
- Defined: a Trigger rise during RUN (no Abort, Enable=1) re-latches the configuration, reloads the dwell counter and restarts at slot 0 on the next cycle. ResultValid drops for AU_LATENCY cycles. No Done is issued.
- Undefined: a rise during RUN is ignored.

Test Plan:
1. Reset=0 mid-run with Dwell=10 → all outputs at reset values in the same cycle, asynchronously. Release → stays IDLE until a new rise.
2. Program=8'b11_10_01_00, NumSteps=3, Dwell=3, Loop=0, AU_LATENCY=1; Trigger rise at t:
   - OpCode = 0,1,2,3 for 3 cycles each, starting t+1.
   - ResultValid high in the 2nd and 3rd cycle of each step.
   - Done pulse at t+13 with Busy=0.
3. Dwell=0, NumSteps=1, Loop=0 → each step lasts 1 cycle, ResultValid never asserted, Done at t+3.
4. Loop=1, NumSteps=1, Dwell=2 → OpCode alternates slot0,slot1 every 2 cycles indefinitely. Enable=0 → IDLE next cycle, Done never pulses.
5. Trigger held high 50 cycles with Dwell=2, NumSteps=0, Loop=0 → exactly one run and one Done. Program changed mid-run → OpCode unaffected.
6. Abort during step 2 of 4 → next cycle Busy=0, OpCode=IDLE_OPCODE, no Done. With SEQ_RETRIG_EN, a rise at step 2 → StepIdx=0 the next cycle.
